div_unit: RTL and testbench

//   Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage. It is the

---
 rtl/div_unit.sv | 137 +++++++++++++
 tb/tb_div_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// Holds the pipeline via stallreq_o until {remainder, quotient} is ready.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BYZERO,
    ST_ON,
    ST_END
  } state_e;

  function automatic logic [DATA_W-1:0] neg_if(input logic en, input logic [DATA_W-1:0] v);
    return en ? (~v + DATA_W'(1)) : v;
  endfunction

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     quot_q, quot_d;
  logic [DATA_W-1:0]     dvsr_q, dvsr_d;
  logic                  neg_quot_q, neg_quot_d;
  logic                  neg_rem_q, neg_rem_d;

  logic [DATA_W:0]       partial;
  logic signed [DATA_W:0] diff;

  // Remainder stays below the divisor, so DATA_W+1 bits suffice and the MSB is the borrow.
  assign partial = {rem_q, quot_q[DATA_W-1]};
  assign diff    = $signed(partial - {1'b0, dvsr_q});

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    result_d   = result_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d    = ST_ON;
            cnt_d      = '0;
            rem_d      = '0;
            quot_d     = neg_if(signed_div_i & opdata1_i[DATA_W-1], opdata1_i);
            dvsr_d     = neg_if(signed_div_i & opdata2_i[DATA_W-1], opdata2_i);
            neg_quot_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_d  = signed_div_i & opdata1_i[DATA_W-1];
          end
        end
      end
      ST_BYZERO: begin
        state_d  = ST_END;
        result_d = '0;
        ready_d  = 1'b1;
      end
      ST_ON: begin
        if (annul_i) begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          state_d  = ST_END;
          result_d = {neg_if(neg_rem_q, rem_q), neg_if(neg_quot_q, quot_q)};
          ready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (diff < 0) begin
            rem_d  = partial[DATA_W-1:0];
            quot_d = {quot_q[DATA_W-2:0], 1'b0};
          end else begin
            rem_d  = diff[DATA_W-1:0];
            quot_d = {quot_q[DATA_W-2:0], 1'b1};
          end
        end
      end
      ST_END: begin
        if (annul_i || !start_i) begin
          state_d  = ST_IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  // Working registers are only meaningful in ON, which is always entered through IDLE.
  always_ff @(posedge clk) begin
    rem_q      <= rem_d;
    quot_q     <= quot_d;
    dvsr_q     <= dvsr_d;
    neg_quot_q <= neg_quot_d;
    neg_rem_q  <= neg_rem_d;
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized DIV/DIVU
// against an arithmetic reference model.
module tb_div_unit;

  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                signed_div;
  logic [DATA_W-1:0]   op1, op2;
  logic                start, annul;
  logic [2*DATA_W-1:0] result;
  logic                ready, stallreq;

  int total = 0;
  int bad   = 0;

  div_unit #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // {remainder, quotient}: truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, input string tag);
    logic [63:0] exp;
    int n, lat;
    bit stall_ok;
    exp      = ref_div(s, a, b);
    lat      = (b == 0) ? 2 : DATA_W + 2;
    n        = 0;
    stall_ok = 1'b1;
    @(negedge clk);
    signed_div = s; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    #1;
    if (!stallreq) stall_ok = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (ready) break;
      if (!stallreq) stall_ok = 1'b0;
      if (scramble) begin
        op1 = $urandom;
        op2 = $urandom;
        signed_div = ~signed_div;
      end
    end
    chk({tag, " latency"}, 65'(n), 65'(lat));
    chk({tag, " stall_held"}, 65'(stall_ok), 65'd1);
    chk({tag, " result"}, 65'(result), 65'(exp));
    chk({tag, " stall_released"}, 65'(stallreq), 65'd0);
    @(negedge clk);
    chk({tag, " hold"}, {ready, result}, {1'b1, exp});
    start = 1'b0;
    @(negedge clk);
    chk({tag, " drop"}, {ready, result}, 65'd0);
  endtask

  initial begin
    bit seen_ready;
    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ready, result}, 65'd0);
    chk("reset_stall", 65'(stallreq), 65'd0);
    rst = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, 1'b0, "divu_100_7");
    run_div(1'b1, -32'sd7, 32'd2, 1'b0, "div_m7_2");
    run_div(1'b1, 32'd7, -32'sd2, 1'b0, "div_7_m2");
    run_div(1'b0, 32'd5, 32'd0, 1'b0, "divu_by_zero");

    // abort mid-divide
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1 chk("annul_stall", 65'(stallreq), 65'd0);
    @(negedge clk);
    chk("annul_ready", 65'(ready), 65'd0);
    start = 1'b0; annul = 1'b0;
    seen_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready) seen_ready = 1'b1;
    end
    chk("annul_no_ready", 65'(seen_ready), 65'd0);
    run_div(1'b0, 32'd9, 32'd3, 1'b0, "divu_9_3_after_annul");

    // start while annulled in IDLE is ignored
    @(negedge clk);
    op1 = 32'd50; op2 = 32'd5; start = 1'b1; annul = 1'b1;
    #1 chk("idle_annul_stall", 65'(stallreq), 65'd0);
    repeat (40) @(negedge clk);
    chk("idle_annul_ready", {ready, result}, 65'd0);
    start = 1'b0; annul = 1'b0;

    // reset mid-divide
    @(negedge clk);
    op1 = 32'hCAFE_F00D; op2 = 32'd13; start = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {ready, result}, 65'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div(1'b0, 32'hCAFE_F00D, 32'd13, 1'b0, "after_reset");

    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_m1");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");
    run_div(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, "scrambled_ops");

    for (int i = 0; i < 15; i++) begin
      logic [31:0] a, b;
      bit s;
      s = bit'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 50);
        2:       b = -$urandom_range(1, 50);
        default: b = $urandom;
      endcase
      run_div(s, a, b, 1'b0, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
